cond_flag_unit: RTL and testbench
=================================

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of statistics counters (used only under COND_FLAG_UNIT_STATS_EN).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 InstrValid  input  1  current instruction is valid this cycle; 0 = bubble.
REQ-005 Cond  input  4  ARM condition field Instr[31:28].
REQ-006 AluFlags  input  4  {n,z,c,v} from the ALU for the current instruction.
REQ-007 FlagW  input  2  [1] requests N,Z update; [0] requests C,V update.
REQ-008 PCS  input  1  instruction writes PC (branch or Rd=R15).
REQ-009 RegW  input  1  instruction writes register file.
REQ-010 MemW  input  1  instruction writes memory.
REQ-011 NoWrite  input  1  compare-class op (CMP/CMN/TST/TEQ), suppresses register write.
REQ-012 PCSrc, RegWrite, MemWrite  output  1 each  gated write enables.
REQ-013 CondEx  output  1  condition passed for current instruction.
REQ-014 Flags  output  4  registered {N,Z,C,V} (CPSR condition bits).
REQ-015 ExecCount, SkipCount  output  CNT_W each  present only under COND_FLAG_UNIT_STATS_EN.

Function
REQ-016 CondEx shall be combinational from Cond and registered Flags, never from AluFlags of the same cycle.
REQ-017 Encodings: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
REQ-018 PCSrc = PCS & CondEx & InstrValid, combinational.
REQ-019 RegWrite = RegW & CondEx & InstrValid & !NoWrite, combinational.
REQ-020 MemWrite = MemW & CondEx & InstrValid, combinational.
REQ-021 On rising edge with InstrValid & CondEx & FlagW[1]: N,Z <= AluFlags n,z; latency one cycle.
REQ-022 On rising edge with InstrValid & CondEx & FlagW[0]: C,V <= AluFlags c,v; the two groups update independently.
REQ-023 Failed condition or InstrValid=0: Flags hold, all write enables 0.
REQ-024 Back-to-back: instruction in cycle k+1 evaluates Cond against Flags written at end of cycle k.
REQ-025 NoWrite with FlagW set still updates Flags (CMP behaviour).

Reset
REQ-026 reset=1 at rising edge: Flags <= 4'b0000; counters <= 0; takes priority over any flag update in the same cycle.
REQ-027 Outputs during reset cycle follow REQ-016..020 from current Flags; reset asserted mid-stream discards the pending flag write.
REQ-028 After reset, Flags=0000, so EQ fails, NE passes, GE passes, LT fails.

Configuration
REQ-029 Macro COND_FLAG_UNIT_STATS_EN defined: ExecCount increments on each cycle with InstrValid & CondEx; SkipCount increments on each cycle with InstrValid & !CondEx; both saturate at 2^CNT_W-1.
REQ-030 Macro undefined: ExecCount/SkipCount ports and counters absent; all other behaviour identical.

Verification
REQ-031 Reset, then Cond=0000 InstrValid=1 RegW=1 -> CondEx=0, RegWrite=0, Flags=0000.
REQ-032 Cycle1 Cond=1110 FlagW=11 AluFlags=0100 NoWrite=1 RegW=1 -> RegWrite=0, Flags=0100 next cycle; cycle2 Cond=0000 PCS=1 -> PCSrc=1.
REQ-033 Flags=0100, Cond=1110 FlagW=10 AluFlags=1011 -> Flags=1000 (C,V retained as 00).
REQ-034 Flags=1000 (N=1,V=0): Cond=1011 LT -> CondEx=1; Cond=1010 GE -> CondEx=0; Cond=1101 LE -> 1; Cond=1111 -> 0.
REQ-035 Cond=0001 fails (Z=1) with FlagW=11 MemW=1 -> MemWrite=0, Flags unchanged; same cycle with reset=1 and passing Cond -> Flags=0000.
REQ-036 STATS_EN, CNT_W=2: 5 passing valid instructions -> ExecCount=3 (saturated); 2 failing -> SkipCount=2; InstrValid=0 cycles leave both unchanged.

Source files
------------

// File: rtl/cond_flag_unit.sv
// ARM-style condition evaluation, write-enable gating and CPSR {N,Z,C,V} flag register.
// Optional COND_FLAG_UNIT_STATS_EN adds saturating executed/skipped instruction counters.
module cond_flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       AluFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
`ifdef COND_FLAG_UNIT_STATS_EN
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount,
`endif
    output logic [3:0]       Flags
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    logic n_f, z_f, c_f, v_f;
    logic fire;

    assign {n_f, z_f, c_f, v_f} = Flags;

    // Evaluated only against the registered flags, never the same-cycle ALU result.
    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = z_f;
            COND_NE: CondEx = ~z_f;
            COND_CS: CondEx = c_f;
            COND_CC: CondEx = ~c_f;
            COND_MI: CondEx = n_f;
            COND_PL: CondEx = ~n_f;
            COND_VS: CondEx = v_f;
            COND_VC: CondEx = ~v_f;
            COND_HI: CondEx = c_f & ~z_f;
            COND_LS: CondEx = ~c_f | z_f;
            COND_GE: CondEx = (n_f == v_f);
            COND_LT: CondEx = (n_f != v_f);
            COND_GT: CondEx = ~z_f & (n_f == v_f);
            COND_LE: CondEx = z_f | (n_f != v_f);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

    assign fire     = InstrValid & CondEx;
    assign PCSrc    = PCS & fire;
    assign RegWrite = RegW & fire & ~NoWrite;
    assign MemWrite = MemW & fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= '0;
        end else if (fire) begin
            if (FlagW[1]) Flags[3:2] <= AluFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= AluFlags[1:0];
        end
    end

`ifdef COND_FLAG_UNIT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ExecCount <= '0;
            SkipCount <= '0;
        end else if (InstrValid) begin
            if (CondEx && ExecCount != '1) ExecCount <= ExecCount + 1'b1;
            if (!CondEx && SkipCount != '1) SkipCount <= SkipCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: driver pushes model expectations, monitor pops and compares.
module tb_cond_flag_unit;

`ifdef COND_FLAG_UNIT_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk = 1'b0;
    logic reset, InstrValid, PCS, RegW, MemW, NoWrite;
    logic [3:0] Cond, AluFlags;
    logic [1:0] FlagW;
    logic PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
`ifdef COND_FLAG_UNIT_STATS_EN
    logic [CNT_W-1:0] ExecCount, SkipCount;
`endif

    cond_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
        .AluFlags(AluFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx),
`ifdef COND_FLAG_UNIT_STATS_EN
        .ExecCount(ExecCount), .SkipCount(SkipCount),
`endif
        .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        condex, pcsrc, regwrite, memwrite;
        logic [3:0]  flags;
        logic [31:0] exec, skip;
        logic [31:0] step;
    } exp_t;

    exp_t exp_q[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned step_no = 0;

    // Reference state
    logic mn, mz, mc, mv;
    int unsigned m_exec, m_skip;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    // ARM condition decode: pair selects a base test, low bit inverts it, 111x special-cased.
    function automatic logic cond_pass(input logic [3:0] c, input logic n, z, cf, v);
        logic base;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c == 4'b1110);
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv, input logic [31:0] st);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, st, act, expv);
        end
    endtask

    task automatic step(input logic rst, input logic vld, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic rw, input logic mw,
                        input logic nw, input bit push);
        exp_t e;
        logic pass;
        @(posedge clk);
        #1;
        reset = rst; InstrValid = vld; Cond = c; AluFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        pass = cond_pass(c, mn, mz, mc, mv);
        e.condex   = pass;
        e.pcsrc    = pcs && pass && vld;
        e.regwrite = rw && pass && vld && !nw;
        e.memwrite = mw && pass && vld;
        e.flags    = {mn, mz, mc, mv};
        e.exec     = m_exec;
        e.skip     = m_skip;
        e.step     = step_no;
        step_no++;
        if (push) exp_q.push_back(e);
        if (rst) begin
            {mn, mz, mc, mv} = 4'b0000;
            m_exec = 0; m_skip = 0;
        end else if (vld) begin
            if (pass) begin
                if (fw[1]) {mn, mz} = alu[3:2];
                if (fw[0]) {mc, mv} = alu[1:0];
                if (m_exec < CNT_MAX) m_exec++;
            end else if (m_skip < CNT_MAX) m_skip++;
        end
    endtask

    // Monitor: every non-reset-init cycle presents a response; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("condex",   32'(CondEx),   32'(e.condex),   e.step);
                chk("pcsrc",    32'(PCSrc),    32'(e.pcsrc),    e.step);
                chk("regwrite", 32'(RegWrite), 32'(e.regwrite), e.step);
                chk("memwrite", 32'(MemWrite), 32'(e.memwrite), e.step);
                chk("flags",    32'(Flags),    32'(e.flags),    e.step);
`ifdef COND_FLAG_UNIT_STATS_EN
                chk("exec_count", 32'(ExecCount), e.exec, e.step);
                chk("skip_count", 32'(SkipCount), e.skip, e.step);
`endif
            end
        end
    end

    initial begin
        int unsigned wait_cycles;
        reset = 1'b1; InstrValid = 1'b0; Cond = '0; AluFlags = '0; FlagW = '0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        {mn, mz, mc, mv} = 4'bxxxx;
        m_exec = 0; m_skip = 0;
        step(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);

        // Post-reset: EQ fails, NE/GE pass, LT fails
        step(0, 1, 4'b0000, 4'b1111, 2'b11, 0, 1, 0, 0, 1);
        step(0, 1, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 1);
        step(0, 1, 4'b1010, 4'b0000, 2'b00, 0, 0, 1, 0, 1);
        step(0, 1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
        // CMP-style write sets Z, then EQ branch takes
        step(0, 1, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1, 1);
        step(0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 1);
        // N,Z-only update keeps C,V
        step(0, 1, 4'b1110, 4'b1011, 2'b10, 0, 0, 0, 0, 1);
        step(0, 1, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        step(0, 1, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        step(0, 1, 4'b1101, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        step(0, 1, 4'b1111, 4'b0000, 2'b11, 1, 1, 1, 0, 1);
        // Bubble with passing cond: no enables, no flag write
        step(0, 0, 4'b1110, 4'b0101, 2'b11, 1, 1, 1, 0, 1);
        // Set Z again, NE fails with MemW, then reset beats a passing flag write
        step(0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 1, 1);
        step(0, 1, 4'b0001, 4'b1111, 2'b11, 0, 0, 1, 0, 1);
        step(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1);
        step(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        // Counter saturation pattern: 5 passing, 2 failing, 2 bubbles
        step(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 1, 4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
        step(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
